multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore-style FSM sequencer for the multi-cycle RV32I-subset core (ADDI-class, R-type, LW, SW, BEQ/BNE,
//  JAL, JALR, LUI). Drives the shared ALU, unified memory port, PC/IR/register-file write enables per step.
//  Sits beside the datapath, fed from the IR; replaces the single-cycle combinational control unit.
// PARAMETERS
//  XLEN   32  instruction/counter width
// PORTS
//  clk        in   1     clock; single clock domain
//  rst        in   1     reset, synchronous, active-high
//  instr      in   32    IR contents (valid from DECODE onward)
//  zero       in   1     ALU zero flag
//  mem_ready  in   1     memory handshake: access done this cycle
//  mem_req    out  1     memory access request
//  mem_we     out  1     memory write (valid with mem_req)
//  addr_src   out  1     0=PC, 1=result bus
//  pc_write   out  1     PC <- result bus
//  ir_write   out  1     IR <- mem rdata; oldPC <- PC
//  reg_write  out  1     register file write of result bus to rd
//  alu_src_a  out  2     00 PC, 01 oldPC, 10 rs1 reg
//  alu_src_b  out  2     00 rs2 reg, 01 immediate, 10 const 4
//  alu_ctrl   out  3     000 add,001 sub,010 and,011 or,100 sll,101 slt,110 passB
//  imm_src    out  3     000 I,001 S,010 B,011 J,100 U
//  result_src out  2     00 ALUOut, 01 mem data reg, 10 ALUResult
//  illegal    out  1     1-cycle pulse: unsupported opcode/funct3
//  instret    out  32    retired-instruction count
// BEHAVIOUR
//  Reset: while rst=1 every output 0, instret=0; next state FETCH. Reset mid-instruction aborts it, no strobe.
//  Outputs are functions of state only, except: pc_write in BRANCH (zero,funct3); FETCH/MEM* strobes gated by mem_ready.
//  Handshake: mem_req held 1 in FETCH/MEMREAD/MEMWRITE until mem_ready=1 sampled; state holds meanwhile.
//  FETCH: mem_req, addr_src=0; on mem_ready: ir_write, pc_write, A=PC B=4 add, result_src=10 -> DECODE.
//  DECODE: A=oldPC B=imm add (imm_src=J for JAL, else B) -> ALUOut=target. Next by opcode:
//   0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL;
//   1100111->JALR; 0110111->LUI; else illegal=1 -> FETCH.
//   R/I funct3 not in {000,001,010,110,111}, or branch funct3 not in {000,001}: illegal=1 -> FETCH.
//  MEMADR: A=rs1 B=imm add (imm_src I for load, S for store) -> MEMREAD (load) / MEMWRITE (store).
//  MEMREAD: mem_req, addr_src=1, result_src=00; on mem_ready -> MEMWB. MEMWB: reg_write, result_src=01 -> FETCH.
//  MEMWRITE: mem_req, mem_we, addr_src=1; on mem_ready -> FETCH.
//  EXECR: A=rs1 B=rs2; EXECI: A=rs1 B=imm(I); alu_ctrl from funct3 via alu_decoder
//   (000 add, sub only if R-type and funct7[5]; 010 slt; 110 or; 111 and; 001 sll) -> ALUWB.
//  ALUWB: reg_write, result_src=00 -> FETCH.
//  BRANCH: A=rs1 B=rs2 sub, result_src=00; pc_write = (funct3==000)?zero:!zero -> FETCH.
//  JAL: result_src=00, pc_write; A=oldPC B=4 add (ALUOut<-link) -> ALUWB.
//  JALR: A=rs1 B=imm(I) add, result_src=10, pc_write -> JALWB.
//   JALWB: A=oldPC B=4 add, result_src=10, reg_write -> FETCH.
//  LUI: B=imm(U), alu_ctrl=passB -> ALUWB.
//  Latency (mem_ready=1): branch 3, ALU/LUI/store 4, JAL/JALR 4, load 5 cycles; +1 per wait cycle.
//  instret +1 (mod 2^32, wraps silently) on each transition into FETCH from a non-illegal, completed
//   instruction; not on illegal or reset.
//  Don't-care outputs driven to 0 (no X). reg_write never asserted with mem_we.
// STRUCTURE
//  riscv_pkg: state_t enum (FETCH,DECODE,MEMADR,MEMREAD,MEMWB,MEMWRITE,EXECR,EXECI,ALUWB,BRANCH,JAL,JALR,JALWB,LUI),
//   opcode, alu_ctrl, imm_src, alu_src_a/b, result_src constants.
//  Sub-module: alu_decoder (funct3, funct7[5], op[5] -> alu_ctrl, funct_ok). FSM + counter in this module.
// TESTING
//  1 rst=1 2 cycles, mem_ready=1 -> all outputs 0; release -> mem_req=1, addr_src=0, instret=0.
//  2 FETCH, mem_ready=0 x3 -> no ir_write/pc_write, state held; ready=1 -> one-cycle ir_write+pc_write, then DECODE.
//  3 addi x1,x0,5 (0x00500093), ready=1 -> FETCH,DECODE,EXECI,ALUWB; reg_write cycle 4, alu_ctrl=000, instret=1.
//  4 lw 0x0000A083, ready=0 2 cycles in MEMREAD -> MEMWB reg_write result_src=01; 7 cycles total.
//  5 beq (0x00208463) zero=1 -> pc_write in BRANCH; bne (0x00209463) zero=1 -> no pc_write; 3 cycles each.
//  6 sub 0x402081B3 -> alu_ctrl=001; opcode 0x0000007F -> illegal pulse after DECODE, no reg_write, instret unchanged;
//    rst during MEMWRITE -> mem_req/mem_we 0 that cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared types and encodings for the multi-cycle RV32I-subset control unit:
// FSM state enum, opcode values and the select/operation encodings that the
// controller drives into the datapath.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      JALWB    = 4'd12,
      LUI      = 4'd13
   } state_t;

   // Opcodes of the supported subset
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALU operations
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_SLL   = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;
   localparam logic [2:0] ALU_PASSB = 3'b110;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU operand selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Result bus selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // BEQ takes the branch on zero, BNE on not-zero
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
      return (funct3 == 3'b000) ? zero : ~zero;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the control FSM and the datapath/memory port.
//  master (controller): reads instr, zero, mem_ready; drives memory request,
//                       datapath selects/enables, illegal pulse, instret.
//  slave  (datapath)  : the mirror image.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [XLEN-1:0] instr;
   logic            zero;
   logic            mem_ready;
   logic            mem_req;
   logic            mem_we;
   logic            addr_src;
   logic            pc_write;
   logic            ir_write;
   logic            reg_write;
   logic [1:0]      alu_src_a;
   logic [1:0]      alu_src_b;
   logic [2:0]      alu_ctrl;
   logic [2:0]      imm_src;
   logic [1:0]      result_src;
   logic            illegal;
   logic [XLEN-1:0] instret;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, addr_src, pc_write, ir_write, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, instret
   );

   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, addr_src, pc_write, ir_write, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, instret
   );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_alu_decoder
// Maps funct3/funct7[5]/op[5] of an R- or I-type instruction onto the ALU
// operation and flags funct3 values the core does not implement.
//  funct3_i   in  3  instruction funct3
//  funct7_5_i in  1  instruction bit 30
//  op5_i      in  1  opcode bit 5 (1 = R-type)
//  alu_ctrl_o out 3  ALU operation
//  funct_ok_o out 1  funct3 is supported
// -----------------------------------------------------------------------------
module multicycle_ctrl_alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   input  logic       op5_i,
   output logic [2:0] alu_ctrl_o,
   output logic       funct_ok_o
);

   // funct3 -> ALU operation; SUB only for R-type, ADDI ignores bit 30
   always_comb begin
      alu_ctrl_o = ALU_ADD;
      funct_ok_o = 1'b1;
      case (funct3_i)
         3'b000:  alu_ctrl_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_ctrl_o = ALU_SLL;
         3'b010:  alu_ctrl_o = ALU_SLT;
         3'b110:  alu_ctrl_o = ALU_OR;
         3'b111:  alu_ctrl_o = ALU_AND;
         default: funct_ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore-style sequencer for the multi-cycle RV32I-subset core. Steps each
// instruction through FETCH/DECODE/execute/writeback states, driving the
// shared ALU, unified memory port and PC/IR/register-file enables, and counts
// retired instructions.
//  clk_i  in  1   clock
//  rst_i  in  1   synchronous active-high reset; forces all outputs to 0
//  bus    master  datapath/memory bundle (see multicycle_ctrl_if)
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   multicycle_ctrl_if.master   bus
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] instret_q, instret_d;
   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [2:0]      dec_alu_ctrl_s;
   logic            funct_ok_s;
   logic            retire_s;
   logic            unused_instr_s;

   assign opcode_s = bus.instr[6:0];
   assign funct3_s = bus.instr[14:12];
   // Register/immediate fields belong to the datapath
   assign unused_instr_s = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

   multicycle_ctrl_alu_decoder u_alu_dec (
      .funct3_i   (funct3_s),
      .funct7_5_i (bus.instr[30]),
      .op5_i      (bus.instr[5]),
      .alu_ctrl_o (dec_alu_ctrl_s),
      .funct_ok_o (funct_ok_s)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-state control outputs; reset forces everything to 0
   always_comb begin
      state_d        = state_q;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.addr_src   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = SRCA_PC;
      bus.alu_src_b  = SRCB_RS2;
      bus.alu_ctrl   = ALU_ADD;
      bus.imm_src    = IMM_I;
      bus.result_src = RES_ALUOUT;
      bus.illegal    = 1'b0;
      if (rst_i) begin
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               bus.mem_req    = 1'b1;
               bus.alu_src_b  = SRCB_FOUR;
               bus.result_src = RES_ALURESULT;
               if (bus.mem_ready) begin
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = DECODE;
               end else begin
                  state_d = FETCH;
               end
            end
            DECODE: begin
               // ALUOut <- oldPC + imm: branch or JAL target, ready for later states
               bus.alu_src_a = SRCA_OLDPC;
               bus.alu_src_b = SRCB_IMM;
               bus.imm_src   = (opcode_s == OP_JAL) ? IMM_J : IMM_B;
               case (opcode_s)
                  OP_LOAD, OP_STORE: state_d = MEMADR;
                  OP_RTYPE: begin
                     state_d     = funct_ok_s ? EXECR : FETCH;
                     bus.illegal = ~funct_ok_s;
                  end
                  OP_ITYPE: begin
                     state_d     = funct_ok_s ? EXECI : FETCH;
                     bus.illegal = ~funct_ok_s;
                  end
                  OP_BRANCH: begin
                     // only BEQ (000) and BNE (001)
                     state_d     = (funct3_s[2:1] == 2'b00) ? BRANCH : FETCH;
                     bus.illegal = (funct3_s[2:1] != 2'b00);
                  end
                  OP_JAL:  state_d = JAL;
                  OP_JALR: state_d = JALR;
                  OP_LUI:  state_d = LUI;
                  default: begin
                     state_d     = FETCH;
                     bus.illegal = 1'b1;
                  end
               endcase
            end
            MEMADR: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_IMM;
               bus.imm_src   = opcode_s[5] ? IMM_S : IMM_I;
               state_d       = opcode_s[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
               bus.mem_req  = 1'b1;
               bus.addr_src = 1'b1;
               state_d      = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
               bus.reg_write  = 1'b1;
               bus.result_src = RES_MEMDATA;
               state_d        = FETCH;
            end
            MEMWRITE: begin
               bus.mem_req  = 1'b1;
               bus.mem_we   = 1'b1;
               bus.addr_src = 1'b1;
               state_d      = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_RS2;
               bus.alu_ctrl  = dec_alu_ctrl_s;
               state_d       = ALUWB;
            end
            EXECI: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_IMM;
               bus.alu_ctrl  = dec_alu_ctrl_s;
               state_d       = ALUWB;
            end
            ALUWB: begin
               bus.reg_write = 1'b1;
               state_d       = FETCH;
            end
            BRANCH: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_RS2;
               bus.alu_ctrl  = ALU_SUB;
               bus.pc_write  = branch_taken(funct3_s, bus.zero);
               state_d       = FETCH;
            end
            JAL: begin
               // PC <- target held in ALUOut while the ALU forms the link address
               bus.pc_write  = 1'b1;
               bus.alu_src_a = SRCA_OLDPC;
               bus.alu_src_b = SRCB_FOUR;
               state_d       = ALUWB;
            end
            JALR: begin
               bus.alu_src_a  = SRCA_RS1;
               bus.alu_src_b  = SRCB_IMM;
               bus.result_src = RES_ALURESULT;
               bus.pc_write   = 1'b1;
               state_d        = JALWB;
            end
            JALWB: begin
               bus.alu_src_a  = SRCA_OLDPC;
               bus.alu_src_b  = SRCB_FOUR;
               bus.result_src = RES_ALURESULT;
               bus.reg_write  = 1'b1;
               state_d        = FETCH;
            end
            LUI: begin
               bus.alu_src_b = SRCB_IMM;
               bus.imm_src   = IMM_U;
               bus.alu_ctrl  = ALU_PASSB;
               state_d       = ALUWB;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // An instruction retires when a post-decode state hands back to FETCH;
   // illegal instructions leave from DECODE and fetch waits loop in FETCH.
   assign retire_s  = (state_d == FETCH) && (state_q != FETCH) && (state_q != DECODE);
   assign instret_d = instret_q + {{(XLEN-1){1'b0}}, retire_s};

   // Retired-instruction counter, wraps silently
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instret_q <= {XLEN{1'b0}};
      end else begin
         instret_q <= instret_d;
      end
   end

   assign bus.instret = rst_i ? {XLEN{1'b0}} : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed self-checking bench for multicycle_ctrl. Inputs change 2 time
// units after a rising edge, outputs are compared 1 unit later.
// Packed output order for outs():
//  {mem_req, mem_we, addr_src, pc_write, ir_write, reg_write,
//   alu_src_a[1:0], alu_src_b[1:0], alu_ctrl[2:0], imm_src[2:0], result_src[1:0], illegal}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LW   = 32'h0000A083;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_BLT  = 32'h0020C463;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SLTU = 32'h0020B1B3;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_LUI  = 32'h000010B7;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   multicycle_ctrl_if bus();

   multicycle_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [18:0] outs();
      return {bus.mem_req, bus.mem_we, bus.addr_src, bus.pc_write, bus.ir_write, bus.reg_write,
              bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.imm_src, bus.result_src, bus.illegal};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leaves the DUT in FETCH with instret = 0, one unit after input update time
   task automatic do_reset();
      rst = 1'b1; bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.instr = 32'h0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [18:0] exp;
      rst = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b1; bus.instr = I_ADDI;
      tick(); tick(); #1;
      exp = 19'b0;
      checks++; if (outs() !== exp) begin failures++; $display("FAIL reset_outs: got %b want %b", outs(), exp); end
      checks++; if (bus.instret !== 32'd0) begin failures++; $display("FAIL reset_instret: got %0d want 0", bus.instret); end
      rst = 1'b0; #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.addr_src !== 1'b0) begin failures++; $display("FAIL release_fetch: got req=%b addr=%b want req=1 addr=0", bus.mem_req, bus.addr_src); end
      checks++; if (bus.instret !== 32'd0) begin failures++; $display("FAIL release_instret: got %0d want 0", bus.instret); end
      tick();
   endtask

   task automatic test_fetch_wait();
      logic [18:0] exp;
      do_reset();
      bus.instr = I_ADDI; bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.mem_req !== 1'b1 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
            failures++; $display("FAIL fetch_wait%0d: got req=%b irw=%b pcw=%b want 1 0 0", i, bus.mem_req, bus.ir_write, bus.pc_write);
         end
         tick();
      end
      bus.mem_ready = 1'b1; #1;
      checks++; if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin failures++; $display("FAIL fetch_ready: got irw=%b pcw=%b want 1 1", bus.ir_write, bus.pc_write); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,3'b000,3'b010,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL fetch_then_decode: got %b want %b", outs(), exp); end
   endtask

   task automatic test_addi();
      logic [18:0] exp;
      do_reset();
      bus.instr = I_ADDI; bus.mem_ready = 1'b1; #1;
      exp = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,3'b000,3'b000,2'b10,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL addi_fetch: got %b want %b", outs(), exp); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,3'b000,3'b010,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL addi_decode: got %b want %b", outs(), exp); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,3'b000,3'b000,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL addi_execi: got %b want %b", outs(), exp); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,3'b000,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL addi_aluwb: got %b want %b", outs(), exp); end
      tick(); #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.addr_src !== 1'b0 || bus.instret !== 32'd1) begin
         failures++; $display("FAIL addi_retire: got req=%b addr=%b instret=%0d want 1 0 1", bus.mem_req, bus.addr_src, bus.instret);
      end
   endtask

   task automatic test_load();
      logic [18:0] exp;
      do_reset();
      bus.instr = I_LW; bus.mem_ready = 1'b1;
      tick(); tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,3'b000,3'b000,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL lw_memadr: got %b want %b", outs(), exp); end
      bus.mem_ready = 1'b0;
      exp = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,3'b000,2'b00,1'b0};
      for (int i = 0; i < 2; i++) begin
         tick(); #1;
         checks++; if (outs() !== exp) begin failures++; $display("FAIL lw_memread_wait%0d: got %b want %b", i, outs(), exp); end
      end
      tick(); bus.mem_ready = 1'b1; #1;
      checks++; if (outs() !== exp) begin failures++; $display("FAIL lw_memread_ready: got %b want %b", outs(), exp); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b000,3'b000,2'b01,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL lw_memwb: got %b want %b", outs(), exp); end
      tick(); #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.addr_src !== 1'b0 || bus.instret !== 32'd1) begin
         failures++; $display("FAIL lw_retire: got req=%b addr=%b instret=%0d want 1 0 1", bus.mem_req, bus.addr_src, bus.instret);
      end
   endtask

   task automatic test_branch();
      logic [18:0] exp;
      do_reset();
      bus.instr = I_BEQ; bus.zero = 1'b1; bus.mem_ready = 1'b1;
      tick(); #1;
      checks++; if (bus.imm_src !== 3'b010) begin failures++; $display("FAIL beq_decode_imm: got %b want 010", bus.imm_src); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,2'b00,3'b001,3'b000,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL beq_taken: got %b want %b", outs(), exp); end
      tick(); #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.addr_src !== 1'b0 || bus.instret !== 32'd1) begin
         failures++; $display("FAIL beq_retire: got req=%b addr=%b instret=%0d want 1 0 1", bus.mem_req, bus.addr_src, bus.instret);
      end
      bus.instr = I_BNE;
      tick(); tick(); #1;
      checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL bne_zero1_pcw: got %b want 0", bus.pc_write); end
      tick(); #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.instret !== 32'd2) begin failures++; $display("FAIL bne_retire: got req=%b instret=%0d want 1 2", bus.mem_req, bus.instret); end
      bus.zero = 1'b0;
      tick(); tick(); #1;
      checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL bne_zero0_pcw: got %b want 1", bus.pc_write); end
      tick();
   endtask

   task automatic test_jumps();
      logic [18:0] exp;
      do_reset();
      bus.instr = I_JAL; bus.mem_ready = 1'b1;
      tick(); #1;
      checks++; if (bus.imm_src !== 3'b011) begin failures++; $display("FAIL jal_decode_imm: got %b want 011", bus.imm_src); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b10,3'b000,3'b000,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL jal_state: got %b want %b", outs(), exp); end
      tick(); #1;
      checks++; if (bus.reg_write !== 1'b1) begin failures++; $display("FAIL jal_aluwb: got %b want 1", bus.reg_write); end
      tick(); bus.instr = I_JALR;
      tick(); tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,2'b01,3'b000,3'b000,2'b10,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL jalr_state: got %b want %b", outs(), exp); end
      tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b10,3'b000,3'b000,2'b10,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL jalwb_state: got %b want %b", outs(), exp); end
      tick(); bus.instr = I_LUI;
      tick(); tick(); #1;
      exp = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,3'b110,3'b100,2'b00,1'b0};
      checks++; if (outs() !== exp) begin failures++; $display("FAIL lui_state: got %b want %b", outs(), exp); end
      tick(); tick(); #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.instret !== 32'd3) begin failures++; $display("FAIL jumps_retire: got req=%b instret=%0d want 1 3", bus.mem_req, bus.instret); end
   endtask

   task automatic test_sub_illegal();
      do_reset();
      bus.instr = I_SUB; bus.mem_ready = 1'b1;
      tick(); #1;
      checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL sub_decode_illegal: got %b want 0", bus.illegal); end
      tick(); #1;
      checks++; if (bus.alu_ctrl !== 3'b001 || bus.alu_src_a !== 2'b10 || bus.alu_src_b !== 2'b00) begin
         failures++; $display("FAIL sub_execr: got ctrl=%b a=%b b=%b want 001 10 00", bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b);
      end
      tick(); tick(); bus.instr = I_BAD;
      tick(); #1;
      checks++; if (bus.illegal !== 1'b1 || bus.reg_write !== 1'b0) begin failures++; $display("FAIL bad_opcode: got ill=%b rw=%b want 1 0", bus.illegal, bus.reg_write); end
      tick(); #1;
      checks++; if (bus.illegal !== 1'b0 || bus.mem_req !== 1'b1 || bus.instret !== 32'd1) begin
         failures++; $display("FAIL bad_after: got ill=%b req=%b instret=%0d want 0 1 1", bus.illegal, bus.mem_req, bus.instret);
      end
      bus.instr = I_SLTU;
      tick(); #1;
      checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL sltu_illegal: got %b want 1", bus.illegal); end
      tick(); bus.instr = I_BLT;
      tick(); #1;
      checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL blt_illegal: got %b want 1", bus.illegal); end
      tick(); bus.instr = I_SW;
      tick(); tick(); #1;
      checks++; if (bus.imm_src !== 3'b001) begin failures++; $display("FAIL sw_memadr_imm: got %b want 001", bus.imm_src); end
      bus.mem_ready = 1'b0;
      tick(); #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.reg_write !== 1'b0) begin
         failures++; $display("FAIL sw_memwrite: got req=%b we=%b rw=%b want 1 1 0", bus.mem_req, bus.mem_we, bus.reg_write);
      end
      rst = 1'b1; #1;
      checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_in_memwrite: got req=%b we=%b want 0 0", bus.mem_req, bus.mem_we); end
      tick(); rst = 1'b0; #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.addr_src !== 1'b0 || bus.mem_we !== 1'b0 || bus.instret !== 32'd0) begin
         failures++; $display("FAIL rst_to_fetch: got req=%b addr=%b we=%b instret=%0d want 1 0 0 0", bus.mem_req, bus.addr_src, bus.mem_we, bus.instret);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [7];
      int          lat  [7];
      int          n;
      prog = '{I_SW, I_BEQ, I_LW, I_JAL, I_JALR, I_LUI, I_ADD};
      lat  = '{4, 3, 5, 4, 4, 4, 4};
      do_reset();
      bus.mem_ready = 1'b1; bus.zero = 1'b0;
      for (int k = 0; k < 7; k++) begin
         bus.instr = prog[k];
         n = 0;
         do begin
            tick(); #1;
            n++;
         end while (!(bus.mem_req === 1'b1 && bus.addr_src === 1'b0) && n < 20);
         checks++; if (n !== lat[k]) begin failures++; $display("FAIL latency_%0d: got %0d cycles want %0d", k, n, lat[k]); end
      end
      checks++; if (bus.instret !== 32'd7) begin failures++; $display("FAIL b2b_instret: got %0d want 7", bus.instret); end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; bus.instr = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      test_reset();
      test_fetch_wait();
      test_addi();
      test_load();
      test_branch();
      test_jumps();
      test_sub_illegal();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
